// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; fixed 32-step latency, no early-out.
module divider (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_flush,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ready;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_dvd;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_op1_orig;
  logic [1:0]    r_op;
  logic          r_sa;
  logic          r_sb;
  logic          r_dz;
  logic [W-1:0]  r_result;

  logic          w_accept;
  logic          w_last;
  logic          w_signed;
  logic [W-1:0]  w_abs1;
  logic [W-1:0]  w_abs2;
  logic [W:0]    w_rem_sh;
  logic          w_ge;
  logic [W:0]    w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;
  logic [W-1:0]  w_quo_fix;
  logic [W-1:0]  w_rem_fix;
  logic [W-1:0]  w_res;

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_result = r_result;

  assign w_accept = (r_state == S_IDLE) && i_valid && !i_flush;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == LAST_CNT) && !i_flush;

  // Operand conditioning at accept: signed ops divide magnitudes
  assign w_signed = !i_op[0];
  assign w_abs1   = (w_signed && i_op1[W-1]) ? (~i_op1 + W'(1)) : i_op1;
  assign w_abs2   = (w_signed && i_op2[W-1]) ? (~i_op2 + W'(1)) : i_op2;

  // One restoring step; R is one bit wider so the compare cannot overflow
  assign w_rem_sh  = {r_rem[W-1:0], r_dvd[W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
  assign w_quo_nxt = {r_dvd[W-2:0], w_ge};

  // Sign fix-up and divide-by-zero selection of the final result
  assign w_quo_fix = (r_sa ^ r_sb) ? (~w_quo_nxt + W'(1)) : w_quo_nxt;
  assign w_rem_fix = r_sa ? (~w_rem_nxt[W-1:0] + W'(1)) : w_rem_nxt[W-1:0];
  always_comb begin
    w_res = '0;
    if (r_dz) w_res = r_op[1] ? r_op1_orig : '1;
    else      w_res = r_op[1] ? w_rem_fix : w_quo_fix;
  end

  // State register plus registered handshake flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (i_flush)                 w_state_nxt = S_IDLE;
        else if (r_cnt == LAST_CNT)  w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in BUSY, write result on step 32
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_op1_orig <= '0;
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dz       <= 1'b0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= w_abs1;
      r_dvs      <= w_abs2;
      r_op1_orig <= i_op1;
      r_op       <= i_op;
      r_sa       <= w_signed && i_op1[W-1];
      r_sb       <= w_signed && i_op2[W-1];
      r_dz       <= (i_op2 == '0);
    end else if (r_state == S_BUSY && !i_flush) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nxt;
      r_dvd <= w_quo_nxt;
      if (w_last) r_result <= w_res;
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: table-driven and randomized checks of the divider against an
// arithmetic reference model, plus handshake, flush and reset sequences.
module tb_divider;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [1:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_flush;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res;

  divider dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_op    (i_op),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .i_flush (i_flush),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_result(o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Reference model straight from the RV32M definitions
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for o_valid after an accept edge; returns edges waited
  task automatic wait_done(output int n, output logic rdy_bad);
    n = 0;
    rdy_bad = 1'b0;
    while (o_valid !== 1'b1 && n < 40) begin
      @(posedge i_clk); #1;
      n++;
      if (o_ready !== 1'b0) rdy_bad = 1'b1;
    end
  endtask

  // Full transaction from IDLE: accept, latency, result, return to ready
  task automatic run_chk(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    logic rb;
    i_op = op; i_op1 = a; i_op2 = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_op1 = $urandom; i_op2 = $urandom;
    chk({nm, "_ready_e0"}, 32'(o_ready), 32'd0);
    wait_done(n, rb);
    chk({nm, "_latency"}, 32'(n), 32'd32);
    chk({nm, "_ready_busy"}, 32'(rb), 32'd0);
    chk({nm, "_result"}, o_result, exp);
    @(posedge i_clk); #1;
    chk({nm, "_idle_after"}, {30'd0, o_ready, o_valid}, 32'd2);
    last_res = exp;
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    int n, cnt;
    logic rb;
    logic [1:0] op;
    logic [31:0] a, b;
    logic [31:0] ra, rbv, rbb;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[6]  = '{2'b00, 32'd12345,      32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678};
    vecs[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE};

    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_op = 2'b00; i_op1 = '0; i_op2 = '0;
    last_res = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 12; i++)
      run_chk($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Randomized operations against the reference model
    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom % 4);
      case ($urandom % 8)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom % 16;
        default: b = $urandom;
      endcase
      a = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
      run_chk($sformatf("rand%0d", i), op, a, b, ref_div(op, a, b));
    end

    // Flush after iteration 10: back to IDLE, no pulse, result untouched
    i_op = 2'b01; i_op1 = 32'd999; i_op2 = 32'd3; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush10_ready", 32'(o_ready), 32'd1);
    count_valid(40, cnt);
    chk("flush10_no_valid", 32'(cnt), 32'd0);
    chk("flush10_result", o_result, last_res);

    // Flush on the step-32 edge wins over the write
    i_op = 2'b01; i_op1 = 32'd1000; i_op2 = 32'd3; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (31) @(posedge i_clk);
    #1;
    chk("flush32_still_busy", {30'd0, o_ready, o_valid}, 32'd0);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush32_state", {30'd0, o_ready, o_valid}, 32'd2);
    chk("flush32_result", o_result, last_res);
    count_valid(36, cnt);
    chk("flush32_no_valid", 32'(cnt), 32'd0);

    // Flush in IDLE blocks an accept
    i_op = 2'b01; i_op1 = 32'd50; i_op2 = 32'd5; i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_ready", 32'(o_ready), 32'd1);
    count_valid(36, cnt);
    chk("flush_idle_no_valid", 32'(cnt), 32'd0);

    // Flush in DONE drops the pulse
    i_op = 2'b01; i_op1 = 32'd81; i_op2 = 32'd9; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_done(n, rb);
    chk("flush_done_result", o_result, 32'd9);
    last_res = 32'd9;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush_done_state", {30'd0, o_ready, o_valid}, 32'd2);

    // i_valid held across two requests; second operands sampled on E33+1
    ra = 32'd1000; rbv = 32'd77777; rbb = 32'd13;
    i_op = 2'b01; i_op1 = ra; i_op2 = 32'd10; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_op = 2'b11; i_op1 = rbv; i_op2 = rbb;
    wait_done(n, rb);
    chk("held_a_latency", 32'(n), 32'd32);
    chk("held_a_result", o_result, 32'd100);
    @(posedge i_clk); #1;
    chk("held_e33_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    chk("held_b_accept", 32'(o_ready), 32'd0);
    i_valid = 1'b0; i_op1 = 32'd1; i_op2 = 32'd1;
    wait_done(n, rb);
    chk("held_b_latency", 32'(n), 32'd32);
    chk("held_b_result", o_result, rbv % rbb);
    @(posedge i_clk); #1;

    // i_valid pulsed during BUSY is ignored
    i_op = 2'b00; i_op1 = 32'hFFFF_FF00; i_op2 = 32'd16; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_op = 2'b11; i_op1 = 32'd5; i_op2 = 32'd0; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    wait_done(n, rb);
    chk("busy_pulse_latency", 32'(n), 32'd26);
    chk("busy_pulse_result", o_result, 32'hFFFF_FFF0);
    @(posedge i_clk); #1;
    count_valid(36, cnt);
    chk("busy_pulse_no_second", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of BUSY
    i_op = 2'b01; i_op1 = 32'd500; i_op2 = 32'd7; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    count_valid(36, cnt);
    chk("rst_mid_no_valid", 32'(cnt), 32'd0);
    run_chk("post_rst", 2'b01, 32'd500, 32'd7, 32'd71);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
